// File: rtl/array_21_req_ctrl.sv
// Request/response front end for the array_21 SRAM (1RW, 1-cycle read latency).
// Define ARRAY21_INIT_EN to zero-fill the whole array after reset release.
module array_21_req_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 256,
  parameter int MASK_W    = 16,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic [MASK_W-1:0] RW0_wmask,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int CR_W  = CNT_W + 1;

  logic                           run_q;
  logic                           run_mode;
  logic                           init_busy;
  logic                           issue;
  logic                           inflight;
  logic                           push;
  logic                           pop;
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               rd_ptr;
  logic [CNT_W-1:0]               fifo_cnt;
  logic [CR_W-1:0]                credit;
  logic [RSP_DEPTH-1:0][DATA_W-1:0] fifo_q;

  function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

`ifdef ARRAY21_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  state_e            state;
  logic [ADDR_W-1:0] init_addr;
  logic              in_init;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else if (run_q && state == ST_INIT) begin
      init_addr <= init_addr + 1'b1;
      if (init_addr == '1) state <= ST_RUN;
    end
  end

  // The sweep only drives the array once run_q is up, so it spans exactly 2**ADDR_W cycles.
  assign in_init   = run_q & (state == ST_INIT);
  assign run_mode  = run_q & (state == ST_RUN);
  assign init_busy = (state == ST_INIT);

  assign RW0_en    = in_init | issue;
  assign RW0_addr  = in_init ? init_addr : req_addr;
  assign RW0_wmode = in_init | req_write;
  assign RW0_wdata = in_init ? '0 : req_wdata;
  assign RW0_wmask = in_init ? '1 : req_wmask;
`else
  assign run_mode  = run_q;
  assign init_busy = 1'b0;

  assign RW0_en    = issue;
  assign RW0_addr  = req_addr;
  assign RW0_wmode = req_write;
  assign RW0_wdata = req_wdata;
  assign RW0_wmask = req_wmask;
`endif

  // A read may only issue if a FIFO slot is guaranteed when its data lands;
  // a same-cycle pop frees a slot so streaming reads sustain one per cycle.
  assign credit    = CR_W'(RSP_DEPTH) - CR_W'(fifo_cnt) - CR_W'(inflight) + CR_W'(pop);
  assign req_ready = run_mode & (req_write | (credit != '0));
  assign issue     = req_valid & req_ready;

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_rdata = fifo_q[rd_ptr];
  assign pop       = rsp_valid & rsp_ready;
  assign push      = inflight;
  assign busy      = inflight | rsp_valid | init_busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      inflight <= issue & ~req_write;
      if (push) wr_ptr <= ptr_nxt(wr_ptr);
      if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Data storage needs no reset; occupancy is tracked by fifo_cnt.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr] <= RW0_rdata;
  end

endmodule

// File: tb/tb_array_21_req_ctrl.sv
// Directed bench for array_21_req_ctrl with a behavioural 4096x256 1RW array model.
module tb_array_21_req_ctrl;

`ifdef ARRAY21_INIT_EN
  localparam int  INIT_CYC = 4096;
  localparam bit  RST_BUSY = 1'b1;
`else
  localparam int  INIT_CYC = 0;
  localparam bit  RST_BUSY = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid, req_ready, req_write;
  logic [11:0]  req_addr;
  logic [255:0] req_wdata;
  logic [15:0]  req_wmask;
  logic         rsp_valid, rsp_ready;
  logic [255:0] rsp_rdata;
  logic         busy;
  logic [11:0]  RW0_addr;
  logic         RW0_en, RW0_wmode;
  logic [255:0] RW0_wdata;
  logic [15:0]  RW0_wmask;
  logic [255:0] RW0_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  array_21_req_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wdata(RW0_wdata), .RW0_wmask(RW0_wmask), .RW0_rdata(RW0_rdata)
  );

  // Array model: masked write per 16-bit group, read data one cycle after issue.
  bit [255:0] mem [4096];
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int g = 0; g < 16; g++)
          if (RW0_wmask[g]) mem[RW0_addr][g*16 +: 16] <= RW0_wdata[g*16 +: 16];
      end else begin
        RW0_rdata <= mem[RW0_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [11:0] a,
                         input logic [255:0] d, input logic [15:0] m);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [255:0] d, input logic [15:0] m);
    set_req(1'b1, 1'b1, a, d, m);
    cyc();
    req_valid = 1'b0;
  endtask

  function automatic logic [255:0] pat_of(input int i);
    return {8{32'hC0DE0000 + 32'(i)}};
  endfunction

  logic [255:0] pat;
  logic [9:0]   vmask;
  int           n, got, acc, stale;
  bit           ok;

  initial begin
    pat = {32{8'hA5}};
    mem[4095] = pat;
    rsp_ready = 1'b0;

    // Reset: request pending must not reach the array
    set_req(1'b1, 1'b1, 12'h123, pat, 16'hFFFF);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rw0_en", RW0_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, RST_BUSY);

    reset_n = 1'b1;
    set_req(1'b0, 1'b1, 12'h0, '0, '0);
    chk("pre_run_ready", req_ready, 0);
    cyc();
`ifdef ARRAY21_INIT_EN
    chk("init_en", RW0_en, 1);
    chk("init_wmode", RW0_wmode, 1);
    chk("init_addr0", RW0_addr, 0);
    chk("init_busy", busy, 1);
`endif
    n = 0;
    while (!req_ready && n < 5000) begin cyc(); n++; end
    chk("run_delay", n, INIT_CYC);

`ifdef ARRAY21_INIT_EN
    set_req(1'b1, 1'b0, 12'hFFF, '0, '0);
    cyc();
    req_valid = 1'b0;
    cyc();
    chk("init_fff_valid", rsp_valid, 1);
    chk("init_fff_zero", rsp_rdata, '0);
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
`endif

    // Full write then read back
    wr(12'h123, pat, 16'hFFFF);
    set_req(1'b1, 1'b0, 12'h123, '0, '0);
    chk("rd_ready", req_ready, 1);
    chk("rd_rw0_en", RW0_en, 1);
    chk("rd_rw0_addr", RW0_addr, 12'h123);
    chk("rd_rw0_wmode", RW0_wmode, 0);
    cyc();
    req_valid = 1'b0;
    #1;
    chk("rd_lat1_valid", rsp_valid, 0);
    chk("rd_lat1_busy", busy, 1);
    cyc();
    chk("rd_lat2_valid", rsp_valid, 1);
    chk("rd_lat2_data", rsp_rdata, pat);
    rsp_ready = 1'b1;
    cyc();
    chk("rd_pop_valid", rsp_valid, 0);
    chk("rd_pop_busy", busy, 0);
    rsp_ready = 1'b0;

    // Partial write then immediate read of the same address
    wr(12'h007, '0, 16'hFFFF);
    wr(12'h007, '1, 16'h0001);
    set_req(1'b1, 1'b0, 12'h007, '0, '0);
    cyc();
    req_valid = 1'b0;
    cyc();
    chk("part_valid", rsp_valid, 1);
    chk("part_data", rsp_rdata, 256'hFFFF);
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;

    // Eight back-to-back reads with the consumer always ready
    for (int i = 0; i < 8; i++) wr(12'h010 + 12'(i), pat_of(i), 16'hFFFF);
    rsp_ready = 1'b1;
    ok = 1'b1; vmask = '0; got = 0;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) set_req(1'b1, 1'b0, 12'h010 + 12'(j), '0, '0);
      else       set_req(1'b0, 1'b0, 12'h0, '0, '0);
      if (j < 8 && !req_ready) ok = 1'b0;
      cyc();
      if (rsp_valid) begin
        vmask[j] = 1'b1;
        chk("b2b_data", rsp_rdata, pat_of(got));
        got++;
      end
    end
    chk("b2b_ready", ok, 1);
    chk("b2b_slots", vmask, 10'h1FE);
    rsp_ready = 1'b0;

    // Backpressure: only two reads fit, writes still flow
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      set_req(1'b1, 1'b0, (acc == 0) ? 12'h123 : 12'h007, '0, '0);
      if (req_ready) acc++;
      cyc();
    end
    chk("bp_accepted", acc, 2);
    set_req(1'b1, 1'b0, 12'h007, '0, '0);
    chk("bp_read_blocked", req_ready, 0);
    set_req(1'b1, 1'b1, 12'h200, pat_of(99), 16'hFFFF);
    chk("bp_write_ok", req_ready, 1);
    cyc();
    req_valid = 1'b0;
    chk("bp_full_valid", rsp_valid, 1);
    chk("bp_head0", rsp_rdata, pat);
    rsp_ready = 1'b1;
    cyc();
    chk("bp_head1_valid", rsp_valid, 1);
    chk("bp_head1", rsp_rdata, 256'hFFFF);
    cyc();
    chk("bp_drained", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Reset with one entry buffered and one read in flight
    set_req(1'b1, 1'b0, 12'h123, '0, '0);
    cyc();
    set_req(1'b1, 1'b0, 12'h007, '0, '0);
    cyc();
    req_valid = 1'b0;
    chk("mid_pre_valid", rsp_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    cyc(); cyc();
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    req_write = 1'b1;
    stale = 0;
    cyc();
    n = 0;
    while (!req_ready && n < 5000) begin
      if (rsp_valid) stale++;
      cyc(); n++;
    end
    chk("mid_run_delay", n, INIT_CYC);
    repeat (6) begin
      if (rsp_valid) stale++;
      cyc();
    end
    chk("mid_no_stale", stale, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
